// File: rtl/fetch_unit.sv
// fetch_unit: PC register, IF/ID register, redirect and optional edge-triggered interrupt entry (FETCH_INTERRUPT_EN)
module fetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter int                INSTR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] INT_VECTOR   = 'h10
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_data,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    input  logic               i_int,
    input  logic               i_int_enable,
    input  logic               i_id_ready,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic               o_int_ack,
    output logic [ADDR_W-1:0]  o_int_ret_pc
);
    logic [ADDR_W-1:0] pc;
    logic              advance;
    logic              take_int;

    assign o_imem_addr = pc;
    assign advance     = !o_valid || i_id_ready;

`ifdef FETCH_INTERRUPT_EN
    logic pending;
    logic int_prev;
    logic int_rise;
    logic int_seen;

    assign int_rise = i_int && !int_prev;
    assign int_seen = pending || int_rise;
    assign take_int = int_seen && i_int_enable && advance && !i_redirect;

    // Edge detect, pending flag and entry bookkeeping; an edge arriving while an
    // older pending request is being taken re-arms the flag
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            int_prev     <= 1'b0;
            pending      <= 1'b0;
            o_int_ack    <= 1'b0;
            o_int_ret_pc <= '0;
        end else begin
            int_prev  <= i_int;
            o_int_ack <= take_int;
            pending   <= take_int ? (pending && int_rise) : int_seen;
            if (take_int)
                o_int_ret_pc <= pc;
        end
    end
`else
    logic unused_int;

    assign unused_int   = i_int ^ i_int_enable;
    assign take_int     = 1'b0;
    assign o_int_ack    = 1'b0;
    assign o_int_ret_pc = '0;
`endif

    // PC and IF/ID register: redirect beats interrupt entry beats advance, else hold
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc      <= RESET_VECTOR;
            o_valid <= 1'b0;
            o_instr <= '0;
            o_pc    <= '0;
        end else if (i_redirect) begin
            pc      <= i_redirect_pc;
            o_valid <= 1'b0;
        end else if (take_int) begin
            pc      <= INT_VECTOR;
            o_valid <= 1'b0;
        end else if (advance) begin
            o_instr <= i_imem_data;
            o_pc    <= pc;
            o_valid <= 1'b1;
            pc      <= pc + ADDR_W'(1);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit with an 8-bit PC to reach the wrap point
module tb_fetch_unit;
    localparam int             AW = 8;
    localparam int             IW = 16;
    localparam logic [AW-1:0]  RV = 8'h00;
    localparam logic [AW-1:0]  IV = 8'h10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          irq = 1'b0;
    logic          irq_en = 1'b0;
    logic          id_ready = 1'b0;
    logic          valid;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          int_ack;
    logic [AW-1:0] int_ret_pc;

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
        return 16'h0100 + IW'(a);
    endfunction

    assign imem_data = mem(imem_addr);

    fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_VECTOR(RV), .INT_VECTOR(IV)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .o_imem_addr(imem_addr), .i_imem_data(imem_data),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_int(irq), .i_int_enable(irq_en),
        .i_id_ready(id_ready), .o_valid(valid), .o_instr(instr), .o_pc(pc),
        .o_int_ack(int_ack), .o_int_ret_pc(int_ret_pc)
    );

    typedef struct packed {
        logic          v;
        logic [AW-1:0] addr;
        logic          ack;
        logic [AW-1:0] ret;
    } ctl_t;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
    } iss_t;

    ctl_t cq[$];
    iss_t iq[$];
    int   tests = 0;
    int   fails = 0;

    logic [AW-1:0] m_pc, m_ret;
    logic          m_valid, m_pend, m_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_ret = '0;
        m_valid = 1'b0;
        m_pend = 1'b0;
        m_prev = 1'b0;
        iq.delete();
    endtask

    // one clock of stimulus; the model predicts the state after the coming rising edge
    task automatic step(input logic red, input logic [AW-1:0] rpc, input logic it, input logic ie, input logic rdy);
        logic adv, entry;
        @(negedge clk);
        rst_n = 1'b1;
        redirect = red;
        redirect_pc = rpc;
        irq = it;
        irq_en = ie;
        id_ready = rdy;
        adv = !m_valid || rdy;
`ifdef FETCH_INTERRUPT_EN
        begin
            logic rise, seen;
            rise = it && !m_prev;
            seen = m_pend || rise;
            entry = seen && ie && adv && !red;
            m_pend = entry ? (m_pend && rise) : seen;
            m_prev = it;
        end
`else
        entry = 1'b0;
`endif
        if (m_valid && !rdy && red && iq.size() != 0)
            void'(iq.pop_front());
        if (red) begin
            m_pc = rpc;
            m_valid = 1'b0;
        end else if (entry) begin
            m_ret = m_pc;
            m_pc = IV;
            m_valid = 1'b0;
        end else if (adv) begin
            iq.push_back(iss_t'{m_pc, mem(m_pc)});
            m_valid = 1'b1;
            m_pc = m_pc + 1'b1;
        end
        cq.push_back(ctl_t'{m_valid, m_pc, entry, m_ret});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(valid), 32'd0);
        chk("async_rst_addr", 32'(imem_addr), 32'(RV));
        chk("async_rst_pc", 32'(pc), 32'd0);
        chk("async_rst_ack", 32'(int_ack), 32'd0);
        model_reset();
        cq.push_back(ctl_t'{1'b0, RV, 1'b0, {AW{1'b0}}});
    endtask

    // monitor: control outputs every cycle, instruction/pc on each accepted IF/ID transfer
    initial begin
        logic          lv;
        logic [AW-1:0] lpc;
        logic [IW-1:0] lins;
        iss_t          e;
        ctl_t          c;
        lv = 1'b0;
        lpc = '0;
        lins = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && lv && id_ready) begin
                chk("issue_expected", 32'(iq.size() != 0), 32'd1);
                if (iq.size() != 0) begin
                    e = iq.pop_front();
                    chk("issue_pc", 32'(lpc), 32'(e.pc));
                    chk("issue_instr", 32'(lins), 32'(e.ins));
                end
            end
            if (cq.size() != 0) begin
                c = cq.pop_front();
                chk("valid", 32'(valid), 32'(c.v));
                chk("imem_addr", 32'(imem_addr), 32'(c.addr));
                chk("int_ack", 32'(int_ack), 32'(c.ack));
                chk("int_ret_pc", 32'(int_ret_pc), 32'(c.ret));
            end
            lv = valid;
            lpc = pc;
            lins = instr;
        end
    end

    initial begin
        #2;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'(RV));
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_ack", 32'(int_ack), 32'd0);
        chk("rst_ret", 32'(int_ret_pc), 32'd0);
        model_reset();
        repeat (6) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h80, 1'b1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        do_reset();
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (600) begin
            if ($urandom_range(0, 99) == 0)
                do_reset();
            step($urandom_range(0, 7) == 0, AW'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(cq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
